addsub_arb: RTL
===============

ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 Parameter FAIR, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 req0_valid  input  1  SHALL indicate a port-0 operation request.
REQ-005 req0_ready  output  1  SHALL indicate port-0 request accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  SHALL carry the port-0 operands.
REQ-007 req0_sub  input  1  SHALL select the port-0 operation: 1 = a-b, 0 = a+b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub SHALL be port 1, identical in width and meaning to port 0.
REQ-009 rsp_valid  output  1  SHALL indicate a result is presented.
REQ-010 rsp_ready  input  1  SHALL indicate the consumer takes the result.
REQ-011 rsp_id  output  1  SHALL give the originating port of the result.
REQ-012 rsp_s  output  32  SHALL carry the result.
REQ-013 rsp_c, rsp_ovf  output  1 each  SHALL carry carry-out and signed overflow.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 The block SHALL contain exactly one 32-bit adder/subtracter computing s = a + (b xor {32{sub}}) + sub, with carry-out c, shared by both ports.
REQ-016 The FSM SHALL have three states, IDLE, EXEC and RESP, with transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, and RESP->IDLE on rsp_ready.
REQ-017 In IDLE, req_ready SHALL be combinational and asserted only to the granted port with valid high; in EXEC and RESP both readies SHALL be 0.
REQ-018 req0_ready and req1_ready SHALL never both be 1.
REQ-019 Grant with one port valid: that port; both valid with FAIR=1: the port named by the priority pointer; both valid with FAIR=0: port 0.
REQ-020 On accept, the block SHALL register a, b, sub and the port id.
REQ-021 In EXEC, the block SHALL register s, c, ovf and id into the rsp_* outputs.
REQ-022 Latency: with accept in cycle N, rsp_valid SHALL be 1 from cycle N+2.
REQ-023 Overflow: add -> ovf = (a[31]==b[31]) && (s[31]!=a[31]); sub -> ovf = (a[31]!=b[31]) && (s[31]!=a[31]).
REQ-024 Carry convention: for sub, c=1 means no borrow (a >= b unsigned).
REQ-025 While rsp_valid=1 && rsp_ready=0, all rsp_* outputs SHALL hold stable.
REQ-026 On the RESP handshake cycle, rsp_valid SHALL fall the next cycle, and the pointer SHALL move to the port not just served (FAIR=1).
REQ-027 Minimum issue interval SHALL be 3 cycles; a request may be accepted in the cycle immediately following a handshake.
REQ-028 Requests with valid high while not in IDLE SHALL wait; no request SHALL be dropped or duplicated.
REQ-029 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-030 On rst, the block SHALL enter IDLE, set the pointer to port 0, and clear rsp_valid, rsp_id, rsp_s, rsp_c, rsp_ovf and busy to 0.
REQ-031 rst asserted in EXEC or RESP SHALL abort the operation; its result SHALL never be presented.

Verification
REQ-032 Port 0: a=0x00000005, b=0x00000003, sub=0 -> rsp_s=0x00000008, c=0, ovf=0, id=0, rsp_valid at accept+2.
REQ-033 Port 1: sub 5-3 -> rsp_s=0x00000002, c=1, ovf=0, id=1; port 1: sub 0-1 -> rsp_s=0xFFFFFFFF, c=0, ovf=0.
REQ-034 0x7FFFFFFF+0x00000001 -> rsp_s=0x80000000, c=0, ovf=1; sub 0x80000000-1 -> rsp_s=0x7FFFFFFF, c=1, ovf=1.
REQ-035 Both ports valid continuously after reset, FAIR=1: ids served 0,1,0,1; FAIR=0: ids served 0,0,0 while port 0 stays valid.
REQ-036 rsp_ready held 0 for 5 cycles in RESP: rsp_* stable, both readies 0, busy=1; accept legal on the cycle after the handshake.
REQ-037 rst pulsed during EXEC: rsp_valid stays 0, busy=0, and the next both-valid grant goes to port 0.

Source files
------------

// File: rtl/addsub_arb.sv
// addsub_arb: two request ports share one 32-bit adder/subtracter through an arbiter.
// Latency: a request accepted in cycle N presents its result from cycle N+2.
// Backpressure: one operation in flight; both readies stay low until the result is taken.
module addsub_arb #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic        rsp_c,
  output logic        rsp_ovf,
  output logic        busy
);

  localparam bit FAIR_EN = (FAIR != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        ptr_q;      // port preferred when both are valid (round-robin only)
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sub_q;
  logic        id_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_s_q;
  logic        rsp_c_q;
  logic        rsp_ovf_q;

  logic        idle;
  logic        grant1;
  logic        accept;
  logic [31:0] b_eff;
  logic [32:0] sum_d;
  logic [31:0] s_d;
  logic        c_d;
  logic        ovf_d;

  // Arbitration: port 1 wins only when it is alone, or when round-robin points at it.
  assign idle       = (state_q == IDLE);
  assign grant1     = req1_valid && (!req0_valid || (FAIR_EN && ptr_q));
  assign req0_ready = idle && req0_valid && !grant1;
  assign req1_ready = idle && grant1;
  assign accept     = req0_ready || req1_ready;

  // The single shared adder: subtraction is a + ~b + 1, so carry-out 1 means no borrow.
  assign b_eff = b_q ^ {32{sub_q}};
  assign sum_d = {1'b0, a_q} + {1'b0, b_eff} + {32'd0, sub_q};
  assign s_d   = sum_d[31:0];
  assign c_d   = sum_d[32];

  // Signed overflow: the effective operands share a sign but the result does not.
  always_comb begin
    ovf_d = 1'b0;
    if (sub_q) begin
      ovf_d = (a_q[31] != b_q[31]) && (s_d[31] != a_q[31]);
    end else begin
      ovf_d = (a_q[31] == b_q[31]) && (s_d[31] != a_q[31]);
    end
  end

  // Control FSM with operand capture, result registers and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= grant1 ? req1_a   : req0_a;
            b_q     <= grant1 ? req1_b   : req0_b;
            sub_q   <= grant1 ? req1_sub : req0_sub;
            id_q    <= grant1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_s_q     <= s_d;
          rsp_c_q     <= c_d;
          rsp_ovf_q   <= ovf_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            // Hand preference to the port that was not just served.
            if (FAIR_EN) begin
              ptr_q <= ~rsp_id_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = !idle;

  // At most one port is ever accepted in a cycle.
  assert property (@(posedge clk) disable iff (rst) !(req0_ready && req1_ready));

  // A stalled response holds every field until the consumer takes it.
  assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_s) && $stable(rsp_id)
                                   && $stable(rsp_c) && $stable(rsp_ovf)));

endmodule
